// File: rtl/clk_wiz_rst_seq.sv
// clk_wiz_rst_seq: lock qualifier and staggered reset sequencer for clk_wiz_0.
// Synchronizes the wizard's locked flag and waits for a stable lock before ungating the clocks.
// It then releases the per-domain resets one at a time, index 0 first.
// While running, it can park the clocks on request, and any lock loss restarts the whole sequence.
module clk_wiz_rst_seq #(
   parameter int N_DOMAINS          = 4,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RELEASE_GAP        = 16
) (
   input  logic                 clk_in1,
   input  logic                 resetn,
   input  logic                 locked,
   input  logic                 gate_req,
   output logic                 clk_gate_en,
   output logic [N_DOMAINS-1:0] rst_out_n,
   output logic                 ready,
   output logic                 gate_ack,
   output logic [7:0]           lock_loss_cnt
);

   // The qualify and release phases never overlap, so they share one counter.
   localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RELEASE_GAP) ? LOCK_STABLE_CYCLES : RELEASE_GAP;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] QUAL_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(RELEASE_GAP - 1);

   typedef enum logic [2:0] {
      S_WAIT_LOCK,
      S_QUALIFY,
      S_GATE_ON,
      S_RELEASE,
      S_RUN,
      S_PARKED
   } state_e;

   state_e                 state_q, state_d;
   logic [1:0]             sync_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   en_q, en_d;
   logic [N_DOMAINS-1:0]   rst_q, rst_d;
   logic                   ready_q, ready_d;
   logic                   ack_q, ack_d;
   logic [7:0]             loss_q, loss_d;
   logic                   locked_s;
   logic                   lock_lost;
   logic [N_DOMAINS-1:0]   rel_next;

   assign locked_s = sync_q[1];

   // Two-flop synchronizer for the wizard's locked flag, which is asynchronous to clk_in1.
   always_ff @(posedge clk_in1 or negedge resetn) begin
      if (!resetn) begin
         sync_q <= 2'b00;
      end else begin
         // NOTE: non-blocking assignments make every flop sample its pre-edge inputs; blocking here would collapse the two stages into one.
         sync_q <= {sync_q[0], locked};
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk_in1 or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_WAIT_LOCK;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         rst_q   <= '0;
         ready_q <= 1'b0;
         ack_q   <= 1'b0;
         loss_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
         ack_q   <= ack_d;
         loss_q  <= loss_d;
      end
   end

   // Next-state logic. A lock loss overrides the per-state decision, which gives it top priority.
   always_comb begin
      // NOTE: every signal is given a hold default first, so no path through the case can infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      en_d     = en_q;
      rst_d    = rst_q;
      ready_d  = ready_q;
      ack_d    = ack_q;
      loss_d   = loss_q;
      rel_next = rst_q << 1;
      rel_next[0] = 1'b1;
      lock_lost = !locked_s &&
                  (state_q inside {S_GATE_ON, S_RELEASE, S_RUN, S_PARKED});

      case (state_q)
         S_WAIT_LOCK: begin
            cnt_d = '0;
            if (locked_s) state_d = S_QUALIFY;
         end
         S_QUALIFY: begin
            if (!locked_s) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == QUAL_LAST) begin
               state_d = S_GATE_ON;
               en_d    = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GATE_ON, S_RELEASE: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               rst_d = rel_next;
               if (&rel_next) begin
                  ready_d = 1'b1;
                  state_d = S_RUN;
               end else begin
                  state_d = S_RELEASE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (gate_req) begin
               state_d = S_PARKED;
               en_d    = 1'b0;
               ack_d   = 1'b1;
            end
         end
         S_PARKED: begin
            if (!gate_req) begin
               state_d = S_RUN;
               en_d    = 1'b1;
               ack_d   = 1'b0;
            end
         end
         default: state_d = S_WAIT_LOCK;
      endcase

      if (lock_lost) begin
         state_d = S_WAIT_LOCK;
         cnt_d   = '0;
         en_d    = 1'b0;
         rst_d   = '0;
         ready_d = 1'b0;
         ack_d   = 1'b0;
         if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
      end
   end

   assign clk_gate_en   = en_q;
   assign rst_out_n     = rst_q;
   assign ready         = ready_q;
   assign gate_ack      = ack_q;
   assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_clk_wiz_rst_seq.sv
// tb_clk_wiz_rst_seq: drives directed scenarios and random lock/gate activity into clk_wiz_rst_seq.
// Outputs are compared on every falling edge against a timeline model (lock run length, age since
// enable), and key instants are pinned with literal values.
`timescale 1ns/1ps
module tb_clk_wiz_rst_seq;
   localparam int N = 3;
   localparam int L = 8;
   localparam int G = 4;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         locked = 1'b0;
   logic         gate_req = 1'b0;
   logic         clk_gate_en;
   logic [N-1:0] rst_out_n;
   logic         ready;
   logic         gate_ack;
   logic [7:0]   lock_loss_cnt;

   int checks = 0;
   int failures = 0;

   clk_wiz_rst_seq #(.N_DOMAINS(N), .LOCK_STABLE_CYCLES(L), .RELEASE_GAP(G)) dut (
      .clk_in1       (clk),
      .resetn        (resetn),
      .locked        (locked),
      .gate_req      (gate_req),
      .clk_gate_en   (clk_gate_en),
      .rst_out_n     (rst_out_n),
      .ready         (ready),
      .gate_ack      (gate_ack),
      .lock_loss_cnt (lock_loss_cnt)
   );

   // 100 MHz reference clock.
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Timeline model: locked is seen two edges late; the clocks are enabled once the synced lock
   // has been high on L+1 consecutive edges; domain k is released G*(k+1) edges after that.
   int m_s0, m_s1, m_run, m_age, m_loss;
   bit m_qual, m_park;

   function automatic int m_released();
      int r;
      r = m_qual ? (m_age / G) : 0;
      return (r > N) ? N : r;
   endfunction

   always @(posedge clk or negedge resetn) begin
      int ls, old_rel;
      if (!resetn) begin
         m_s0 = 0; m_s1 = 0; m_run = 0; m_age = 0; m_loss = 0;
         m_qual = 0; m_park = 0;
      end else begin
         ls      = m_s1;
         old_rel = m_released();
         m_s1    = m_s0;
         m_s0    = int'(locked);
         if (!m_qual) begin
            m_run = ls ? m_run + 1 : 0;
            if (m_run == L + 1) begin
               m_qual = 1; m_age = 0; m_park = 0; m_run = 0;
            end
         end else if (ls == 0) begin
            m_qual = 0; m_park = 0; m_run = 0; m_age = 0;
            if (m_loss < 255) m_loss++;
         end else begin
            m_age++;
            if (old_rel == N) m_park = gate_req;
         end
      end
   end

   // Compare process: all outputs against the model, away from the active edge.
   always @(negedge clk) begin
      int rel;
      if (resetn) begin
         rel = m_released();
         check("model_clk_gate_en", 32'(clk_gate_en), 32'(m_qual && !m_park));
         check("model_rst_out_n", 32'(rst_out_n), 32'((1 << rel) - 1));
         check("model_ready", 32'(ready), 32'(rel == N));
         check("model_gate_ack", 32'(gate_ack), 32'(m_park));
         check("model_lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
      end
   end

   // Advance n active edges and land 1 ns after the last one.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reset, check reset values, then release with locked set so the next edge is E0.
   task automatic power_up(input logic lock_at_e0);
      resetn = 1'b0; locked = 1'b0; gate_req = 1'b0;
      step(3);
      check("rst_clk_gate_en", 32'(clk_gate_en), 32'd0);
      check("rst_rst_out_n", 32'(rst_out_n), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_gate_ack", 32'(gate_ack), 32'd0);
      check("rst_lock_loss_cnt", 32'(lock_loss_cnt), 32'd0);
      locked = lock_at_e0;
      resetn = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // Scenario 1: power-up timing.
      power_up(1'b1);
      step(10);
      check("pu_gate_E9", 32'(clk_gate_en), 32'd0);
      step(1);
      check("pu_gate_E10", 32'(clk_gate_en), 32'd1);
      check("pu_rst_E10", 32'(rst_out_n), 32'd0);
      step(4);
      check("pu_rst_E14", 32'(rst_out_n), 32'b001);
      step(4);
      check("pu_rst_E18", 32'(rst_out_n), 32'b011);
      step(3);
      check("pu_ready_E21", 32'(ready), 32'd0);
      step(1);
      check("pu_rst_E22", 32'(rst_out_n), 32'b111);
      check("pu_ready_E22", 32'(ready), 32'd1);

      // Scenario 4: park handshake.
      gate_req = 1'b1;
      step(1);
      check("park_gate", 32'(clk_gate_en), 32'd0);
      check("park_ack", 32'(gate_ack), 32'd1);
      check("park_rst", 32'(rst_out_n), 32'b111);
      check("park_ready", 32'(ready), 32'd1);
      step(2);
      gate_req = 1'b0;
      step(1);
      check("unpark_gate", 32'(clk_gate_en), 32'd1);
      check("unpark_ack", 32'(gate_ack), 32'd0);

      // Scenario 3: lock loss in RUN, then re-lock.
      locked = 1'b0;
      step(2);
      check("loss_gate_early", 32'(clk_gate_en), 32'd1);
      step(1);
      check("loss_gate", 32'(clk_gate_en), 32'd0);
      check("loss_rst", 32'(rst_out_n), 32'd0);
      check("loss_ready", 32'(ready), 32'd0);
      check("loss_cnt", 32'(lock_loss_cnt), 32'd1);
      locked = 1'b1;
      step(10);
      check("relock_gate_E9", 32'(clk_gate_en), 32'd0);
      step(1);
      check("relock_gate_E10", 32'(clk_gate_en), 32'd1);
      step(12);
      check("relock_rst_E22", 32'(rst_out_n), 32'b111);

      // Scenario 2: qualify abort without counting a loss.
      power_up(1'b1);
      step(5);
      locked = 1'b0;
      step(1);
      locked = 1'b1;
      step(10);
      check("abort_gate_E15", 32'(clk_gate_en), 32'd0);
      check("abort_cnt", 32'(lock_loss_cnt), 32'd0);
      step(1);
      check("abort_gate_E16", 32'(clk_gate_en), 32'd1);

      // Scenario 5a: gate_req during RELEASE is ignored.
      power_up(1'b1);
      step(15);
      gate_req = 1'b1;
      step(3);
      check("rel_req_ack", 32'(gate_ack), 32'd0);
      check("rel_req_gate", 32'(clk_gate_en), 32'd1);
      gate_req = 1'b0;
      step(5);
      check("rel_req_ready", 32'(ready), 32'd1);

      // Scenario 5b: lock loss while parked.
      gate_req = 1'b1;
      step(1);
      check("pk_ack", 32'(gate_ack), 32'd1);
      locked = 1'b0;
      step(3);
      check("pk_loss_ack", 32'(gate_ack), 32'd0);
      check("pk_loss_gate", 32'(clk_gate_en), 32'd0);
      check("pk_loss_rst", 32'(rst_out_n), 32'd0);
      check("pk_loss_cnt", 32'(lock_loss_cnt), 32'd1);
      gate_req = 1'b0;

      // Scenario 5c: counter saturation after 300 losses.
      power_up(1'b1);
      for (int i = 0; i < 300; i++) begin
         step(11);
         locked = 1'b0;
         step(3);
         locked = 1'b1;
      end
      check("sat_cnt", 32'(lock_loss_cnt), 32'd255);

      // Random lock/gate activity checked by the model.
      power_up(1'b1);
      for (int i = 0; i < 4000; i++) begin
         step(1);
         if (locked ? ($urandom % 150 == 0) : ($urandom % 6 == 0)) locked = ~locked;
         if ($urandom % 10 == 0) gate_req = ~gate_req;
      end

      // Scenario 6: async reset mid-RELEASE, no clock edge in between.
      power_up(1'b1);
      step(16);
      check("ar_pre_rst", 32'(rst_out_n), 32'b001);
      #1 resetn = 1'b0;
      #1;
      check("ar_gate", 32'(clk_gate_en), 32'd0);
      check("ar_rst", 32'(rst_out_n), 32'd0);
      check("ar_ready", 32'(ready), 32'd0);
      check("ar_ack", 32'(gate_ack), 32'd0);
      check("ar_cnt", 32'(lock_loss_cnt), 32'd0);
      #1 resetn = 1'b1;
      step(22);
      check("ar_ready_E21", 32'(ready), 32'd0);
      step(1);
      check("ar_ready_E22", 32'(ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
